mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (legal >= 2).
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles per multiply (legal >= 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles per divide (legal >= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Start  input  1  request strobe, sampled on the rising clock edge.
REQ-007 SHALL have port MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-008 SHALL have port A  input  WIDTH  first operand (dividend / multiplicand / mthi-mtlo source).
REQ-009 SHALL have port B  input  WIDTH  second operand (divisor / multiplier).
REQ-010 SHALL have port Busy  output  1  operation in progress.
REQ-011 SHALL have port Done  output  1  one-cycle pulse when HI/LO take a new mult/div result.
REQ-012 SHALL have port HI  output  WIDTH  HI register (product upper half / remainder).
REQ-013 SHALL have port LO  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-014 SHALL accept a request only on an edge where Start=1 and Busy=0; a Start seen while Busy=1 SHALL be ignored entirely, mthi/mtlo included.
REQ-015 SHALL, on an accepted MDOp 1-4, latch A, B and MDOp internally; later changes on A/B/MDOp SHALL NOT affect the result.
REQ-016 SHALL use states IDLE and RUN: IDLE->RUN on an accepted MDOp 1-4; RUN->IDLE when the cycle counter expires; MDOp 0/5/6/7 SHALL stay in IDLE.
REQ-017 SHALL drive Busy=1 from the accepting edge E0 until edge E0+N, where N = MULT_CYCLES (MDOp 1/2) or DIV_CYCLES (MDOp 3/4).
REQ-018 SHALL keep HI/LO at their old values while Busy=1, then write them at edge E0+N, clear Busy and assert Done for exactly that following cycle.
REQ-019 SHALL allow a new Start to be accepted in the same cycle Done=1, giving back-to-back operations with no idle gap.
REQ-020 mult: {HI,LO} SHALL equal the 2*WIDTH-bit two's-complement product of A and B; multu: the unsigned product.
REQ-021 div: LO SHALL be the signed quotient truncated toward zero; HI SHALL be the remainder, carrying the sign of A.
REQ-022 divu: LO SHALL be the unsigned quotient and HI the unsigned remainder.
REQ-023 Divide by zero (div or divu) SHALL give LO = all ones and HI = A, with Busy timing unchanged.
REQ-024 Signed overflow (A = most-negative, B = -1) SHALL give LO = A and HI = 0.
REQ-025 mthi/mtlo SHALL write A into HI/LO at the accepting edge, leave the other register unchanged, keep Busy=0 and Done=0.
REQ-026 SHALL NOT allow MDOp 0 or 7 with Start=1 to change any state.

Reset
REQ-027 While reset_n=0, SHALL immediately and asynchronously drive Busy=0, Done=0, HI=0, LO=0, return to IDLE and clear the counter and latched operands, including mid-operation; no result from an interrupted operation SHALL appear.
REQ-028 SHALL accept a Start on the first rising edge after reset_n deasserts.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-029 SHALL check mult with A=ffff0000, B=00000010 -> Busy=1 for 5 cycles, then HI=ffffffff, LO=fff00000, Done pulse 1 cycle; multu with the same operands -> HI=0000000f, LO=fff00000.
REQ-030 SHALL check div with A=fffffff9, B=00000002 -> after 10 cycles LO=fffffffd, HI=ffffffff; divu with the same operands -> LO=7ffffffc, HI=00000001.
REQ-031 SHALL check div with A=00000005, B=0 -> LO=ffffffff, HI=00000005; div with A=80000000, B=ffffffff -> LO=80000000, HI=00000000.
REQ-032 SHALL check that during a busy mult, Start with MDOp=5, A=12345678 -> ignored, and the final HI equals the product's upper half.
REQ-033 SHALL check that reset_n pulled low at busy cycle 3 of a div -> Busy, HI, LO become 0 without waiting for a clock edge, and no Done pulse follows.
REQ-034 SHALL check back-to-back operation: mtlo A=000000aa, then Start=1 with mult in the Done cycle -> mult accepted, and LO=000000aa holds until the mult result lands.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with HI/LO registers and fixed-latency busy timing
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a, b;
  logic               is_md, is_mul, sa, sb;
  logic [2*WIDTH-1:0] ae, be, prod, res;
  logic [WIDTH-1:0]   ma, mb, mbg, q, r, qs, rs;
  assign is_md  = MDOp >= 3'd1 && MDOp <= 3'd4;
  assign is_mul = op == 3'd1 || op == 3'd2;
  // Result datapath from latched operands; division works on magnitudes so
  // the most-negative / -1 case naturally yields LO = A, HI = 0.
  always_comb begin
    ae   = (op == 3'd1) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    be   = (op == 3'd1) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = ae * be;
    sa   = (op == 3'd3) & a[WIDTH-1];
    sb   = (op == 3'd3) & b[WIDTH-1];
    ma   = sa ? -a : a;
    mb   = sb ? -b : b;
    mbg  = (mb == '0) ? WIDTH'(1) : mb;
    q    = ma / mbg;
    r    = ma % mbg;
    qs   = (sa ^ sb) ? -q : q;
    rs   = sa ? -r : r;
    res  = is_mul ? prod : (b == '0) ? {a, {WIDTH{1'b1}}} : {rs, qs};
  end
  // Control FSM, operand latches and HI/LO registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start && is_md) begin
          state <= RUN;
          Busy  <= 1'b1;
          op    <= MDOp;
          a     <= A;
          b     <= B;
          cnt   <= (MDOp <= 3'd2) ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end else if (Start && MDOp == 3'd5) begin
          HI <= A;
        end else if (Start && MDOp == 3'd6) begin
          LO <= A;
        end
      end else if (cnt == '0) begin
        state <= IDLE;
        Busy  <= 1'b0;
        Done  <= 1'b1;
        HI    <= res[2*WIDTH-1:WIDTH];
        LO    <= res[WIDTH-1:0];
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed table-driven bench for mdu_seq with multi-cycle corner sequences
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy, Done;
  logic [31:0] HI, LO;
  int          n_chk = 0;
  int          n_fail = 0;

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    bit          intrude;
  } vec_t;
  vec_t v[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one mult/div, scramble inputs after acceptance, count busy cycles,
  // verify HI/LO hold and Done stays low while busy, then check the result.
  task automatic run_md(input vec_t t);
    int          cyc;
    bit          bad;
    logic [63:0] prev;
    int          n;
    n = (t.op <= 3'd2) ? 5 : 10;
    @(negedge clk);
    prev = {HI, LO};
    Start = 1'b1; MDOp = t.op; A = t.a; B = t.b;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
    cyc = 0;
    bad = 1'b0;
    while (Busy && cyc < 100) begin
      cyc++;
      if ({HI, LO} !== prev || Done !== 1'b0) bad = 1'b1;
      if (t.intrude && cyc == 2) begin Start = 1'b1; MDOp = 3'd5; A = 32'h12345678; end
      if (t.intrude && cyc == 3) begin Start = 1'b0; MDOp = 3'd0; end
      @(negedge clk);
    end
    chk("busy_cycles", 64'(cyc), 64'(n));
    chk("hold_while_busy", 64'(bad), 64'd0);
    chk("done_pulse", 64'(Done), 64'd1);
    chk("hi", 64'(HI), 64'(t.hi));
    chk("lo", 64'(LO), 64'(t.lo));
    @(negedge clk);
    chk("done_drop", 64'(Done), 64'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    v[0] = '{3'd1, 32'hffff0000, 32'h00000010, 32'hffffffff, 32'hfff00000, 1'b0};
    v[1] = '{3'd2, 32'hffff0000, 32'h00000010, 32'h0000000f, 32'hfff00000, 1'b0};
    v[2] = '{3'd3, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 1'b0};
    v[3] = '{3'd4, 32'hfffffff9, 32'h00000002, 32'h00000001, 32'h7ffffffc, 1'b0};
    v[4] = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hffffffff, 1'b0};
    v[5] = '{3'd3, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0};
    v[6] = '{3'd4, 32'h00000007, 32'h00000000, 32'h00000007, 32'hffffffff, 1'b0};
    v[7] = '{3'd3, 32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd, 1'b0};
    v[8] = '{3'd1, 32'hffffffff, 32'hffffffff, 32'h00000000, 32'h00000001, 1'b0};
    v[9] = '{3'd1, 32'hffff0000, 32'h00000010, 32'hffffffff, 32'hfff00000, 1'b1};

    #2;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);

    @(negedge clk);
    reset_n = 1'b1; Start = 1'b1; MDOp = 3'd5; A = 32'hcafe0001;
    @(negedge clk);
    chk("mthi_first_edge", 64'(HI), 64'h00000000cafe0001);
    MDOp = 3'd6; A = 32'hbeef0002;
    @(negedge clk);
    chk("mtlo_lo", 64'(LO), 64'h00000000beef0002);
    chk("mtlo_hi_kept", 64'(HI), 64'h00000000cafe0001);
    chk("mtx_no_busy", 64'({Busy, Done}), 64'd0);
    MDOp = 3'd0; A = 32'h11111111;
    @(negedge clk);
    MDOp = 3'd7; A = 32'h22222222;
    @(negedge clk);
    Start = 1'b0;
    chk("nop_hilo", {HI, LO}, 64'hcafe0001beef0002);
    chk("nop_busy", 64'(Busy), 64'd0);

    for (int i = 0; i < 10; i++) run_md(v[i]);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd5; A = 32'h00000055;
    @(negedge clk);
    MDOp = 3'd3; A = 32'h00000064; B = 32'h00000007;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    @(negedge clk);
    @(negedge clk);
    chk("div_busy_c3", 64'(Busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_busy", 64'(Busy), 64'd0);
    chk("async_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (Done || Busy) seen = 1'b1;
    end
    chk("no_done_after_rst", 64'(seen), 64'd0);
    chk("hilo_after_rst", {HI, LO}, 64'd0);

    // Back-to-back: mtlo, mult, second mult accepted in the Done cycle
    Start = 1'b1; MDOp = 3'd6; A = 32'h000000aa;
    @(negedge clk);
    MDOp = 3'd1; A = 32'h00000003; B = 32'h00000005;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    chk("b2b_lo_aa", 64'(LO), 64'h00000000000000aa);
    cyc = 0;
    seen = 1'b0;
    while (!Done && cyc < 100) begin
      if (LO !== 32'h000000aa) seen = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk("b2b_lo_held", 64'(seen), 64'd0);
    chk("b2b_first_res", {HI, LO}, 64'h000000000000000f);
    Start = 1'b1; MDOp = 3'd2; A = 32'h00000002; B = 32'h00000004;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    chk("b2b_accepted", 64'(Busy), 64'd1);
    cyc = 0;
    while (Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", 64'(cyc), 64'd5);
    chk("b2b_second_res", {HI, LO}, 64'h0000000000000008);
    chk("b2b_done", 64'(Done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
